// File: rtl/sequence_checker_if.sv
// Link-side signal bundle for the LFSR sequence checker: serial input, counter clear,
// and the lock/error status returned to the host.
interface sequence_checker_if #(
   parameter int CNT_W = 8
) ();
   logic             din;
   logic             din_valid;
   logic             clr_cnt;
   logic             locked;
   logic             err;
   logic [CNT_W-1:0] err_count;
   logic             err_flag;

   modport master (
      output din, din_valid, clr_cnt,
      input  locked, err, err_count, err_flag
   );

   modport slave (
      input  din, din_valid, clr_cnt,
      output locked, err, err_count, err_flag
   );
endinterface

// File: rtl/sequence_checker.sv
// Receive-side checker for the x^3+x^2+1 style 3-bit LFSR stream: self-synchronises,
// locks, then flywheels on its own prediction and counts bit errors.
module sequence_checker #(
   parameter int LOCK_THRESH   = 7,
   parameter int UNLOCK_THRESH = 3,
   parameter int CNT_W         = 8
) (
   input logic               clk,
   input logic               reset,
   sequence_checker_if.slave bus
);
   typedef enum logic [1:0] {
      SEED   = 2'd0,
      HUNT   = 2'd1,
      LOCKED = 2'd2
   } state_t;

   localparam logic [3:0]       LOCK_T   = 4'(LOCK_THRESH);
   localparam logic [3:0]       UNLOCK_T = 4'(UNLOCK_THRESH);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

   // h[0] is the newest accepted bit, h[2] the oldest
   function automatic logic lfsr_pred(input logic [2:0] h);
      return h[0] ^ h[2];
   endfunction

   state_t           state_r, next_state_s;
   logic [2:0]       hist_r, next_hist_s;
   logic [1:0]       fill_r, next_fill_s;
   logic [3:0]       match_r, next_match_s;
   logic [3:0]       miss_r, next_miss_s;
   logic             err_r, locked_r, flag_r, next_flag_s;
   logic [CNT_W-1:0] cnt_r, next_cnt_s;
   logic             pred_s, hit_s, bump_s;

   // Next-state, history and error bookkeeping for one sampled bit
   always_comb begin
      next_state_s = state_r;
      next_hist_s  = hist_r;
      next_fill_s  = fill_r;
      next_match_s = match_r;
      next_miss_s  = miss_r;
      bump_s       = 1'b0;
      pred_s       = lfsr_pred(hist_r);
      hit_s        = (bus.din == pred_s);
      if (bus.din_valid) begin
         case (state_r)
            SEED: begin
               next_hist_s = {hist_r[1:0], bus.din};
               next_fill_s = fill_r + 2'd1;
               if (fill_r == 2'd2) begin
                  next_state_s = HUNT;
                  next_match_s = 4'd0;
               end else begin
                  next_state_s = SEED;
               end
            end
            HUNT: begin
               next_hist_s = {hist_r[1:0], bus.din};
               // an all-zero history is the LFSR lock-up state and must never qualify
               if (hit_s && (hist_r != 3'b000)) begin
                  if (match_r == (LOCK_T - 4'd1)) begin
                     next_state_s = LOCKED;
                     next_match_s = 4'd0;
                     next_miss_s  = 4'd0;
                  end else begin
                     next_match_s = match_r + 4'd1;
                  end
               end else begin
                  next_match_s = 4'd0;
               end
            end
            LOCKED: begin
               next_hist_s = {hist_r[1:0], pred_s};
               if (hit_s) begin
                  next_miss_s = 4'd0;
               end else begin
                  bump_s = 1'b1;
                  if (miss_r == (UNLOCK_T - 4'd1)) begin
                     next_state_s = SEED;
                     next_fill_s  = 2'd0;
                     next_hist_s  = 3'b000;
                     next_miss_s  = 4'd0;
                  end else begin
                     next_miss_s = miss_r + 4'd1;
                  end
               end
            end
            default: begin
               next_state_s = SEED;
               next_hist_s  = 3'b000;
               next_fill_s  = 2'd0;
               next_match_s = 4'd0;
               next_miss_s  = 4'd0;
            end
         endcase
      end else begin
         next_state_s = state_r;
      end

      if (bus.clr_cnt) begin
         next_cnt_s  = {CNT_W{1'b0}};
         next_flag_s = 1'b0;
      end else if (bump_s) begin
         next_cnt_s  = (cnt_r == CNT_MAX) ? cnt_r : (cnt_r + CNT_ONE);
         next_flag_s = 1'b1;
      end else begin
         next_cnt_s  = cnt_r;
         next_flag_s = flag_r;
      end
   end

   // State and output registers, cleared asynchronously
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r  <= SEED;
         hist_r   <= 3'b000;
         fill_r   <= 2'd0;
         match_r  <= 4'd0;
         miss_r   <= 4'd0;
         err_r    <= 1'b0;
         locked_r <= 1'b0;
         flag_r   <= 1'b0;
         cnt_r    <= {CNT_W{1'b0}};
      end else begin
         state_r  <= next_state_s;
         hist_r   <= next_hist_s;
         fill_r   <= next_fill_s;
         match_r  <= next_match_s;
         miss_r   <= next_miss_s;
         err_r    <= bump_s;
         locked_r <= (next_state_s == LOCKED);
         flag_r   <= next_flag_s;
         cnt_r    <= next_cnt_s;
      end
   end

   assign bus.locked    = locked_r;
   assign bus.err       = err_r;
   assign bus.err_count = cnt_r;
   assign bus.err_flag  = flag_r;
endmodule

// File: tb/tb_sequence_checker.sv
// Randomised self-checking bench for sequence_checker against a queue-based reference
// model of the lock/flywheel/error-count rules.
module tb_sequence_checker;
   localparam int LOCK_THRESH   = 7;
   localparam int UNLOCK_THRESH = 3;
   localparam int CNT_W         = 8;
   localparam int CNT_MAX       = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   sequence_checker_if #(.CNT_W(CNT_W)) bus ();

   sequence_checker #(
      .LOCK_THRESH(LOCK_THRESH),
      .UNLOCK_THRESH(UNLOCK_THRESH),
      .CNT_W(CNT_W)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_cmp = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   // reference model: hq holds accepted history, oldest first
   bit hq[$];
   bit m_locked, m_err, m_flag;
   int m_cnt, m_match, m_miss;

   bit seq_bits [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
   int k = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      hq.delete();
      m_locked = 1'b0;
      m_err    = 1'b0;
      m_flag   = 1'b0;
      m_cnt    = 0;
      m_match  = 0;
      m_miss   = 0;
   endtask

   task automatic model_step(input bit d, input bit v, input bit c);
      bit pred;
      m_err = 1'b0;
      if (v) begin
         if (hq.size() < 3) begin
            hq.push_back(d);
            if (hq.size() == 3) m_match = 0;
         end else begin
            pred = hq[2] ^ hq[0];
            if (!m_locked) begin
               if (d == pred && (hq[0] | hq[1] | hq[2])) m_match++;
               else m_match = 0;
               hq.push_back(d);
               void'(hq.pop_front());
               if (m_match == LOCK_THRESH) begin
                  m_locked = 1'b1;
                  m_match  = 0;
                  m_miss   = 0;
               end
            end else begin
               hq.push_back(pred);
               void'(hq.pop_front());
               if (d != pred) begin
                  m_err  = 1'b1;
                  m_cnt  = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
                  m_flag = 1'b1;
                  m_miss++;
                  if (m_miss == UNLOCK_THRESH) begin
                     m_locked = 1'b0;
                     m_miss   = 0;
                     hq.delete();
                  end
               end else begin
                  m_miss = 0;
               end
            end
         end
      end
      if (c) begin
         m_cnt  = 0;
         m_flag = 1'b0;
      end
   endtask

   task automatic step(input bit d, input bit v, input bit c);
      bus.din       = d;
      bus.din_valid = v;
      bus.clr_cnt   = c;
      @(posedge clk);
      model_step(d, v, c);
      #1;
   endtask

   task automatic clean(input int n);
      for (int i = 0; i < n; i++) begin
         step(seq_bits[k % 7], 1'b1, 1'b0);
         k++;
      end
   endtask

   task automatic bad(input int n);
      for (int i = 0; i < n; i++) begin
         step(~seq_bits[k % 7], 1'b1, 1'b0);
         k++;
      end
   endtask

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (cmp_en && reset) begin
         chk("locked", {31'd0, bus.locked}, {31'd0, m_locked});
         chk("err", {31'd0, bus.err}, {31'd0, m_err});
         chk("err_count", {24'd0, bus.err_count}, m_cnt);
         chk("err_flag", {31'd0, bus.err_flag}, {31'd0, m_flag});
      end
   end

   initial begin
      int burst;
      bit v, d, c;
      bus.din = 1'b0;
      bus.din_valid = 1'b0;
      bus.clr_cnt = 1'b0;
      #1 reset = 1'b0;
      model_reset();
      #1;
      chk("rst_locked", {31'd0, bus.locked}, 32'd0);
      chk("rst_err_count", {24'd0, bus.err_count}, 32'd0);
      chk("rst_err_flag", {31'd0, bus.err_flag}, 32'd0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      cmp_en = 1'b1;

      // clean stream locks on the 10th valid bit
      k = 0;
      clean(9);
      chk("t1_not_locked_9", {31'd0, bus.locked}, 32'd0);
      clean(1);
      chk("t1_locked_10", {31'd0, bus.locked}, 32'd1);
      clean(20);
      chk("t1_err_count", {24'd0, bus.err_count}, 32'd0);

      // single line error
      bad(1);
      chk("t2_err", {31'd0, bus.err}, 32'd1);
      chk("t2_err_count", {24'd0, bus.err_count}, 32'd1);
      chk("t2_err_flag", {31'd0, bus.err_flag}, 32'd1);
      chk("t2_locked", {31'd0, bus.locked}, 32'd1);
      clean(1);
      chk("t2_err_pulse_end", {31'd0, bus.err}, 32'd0);
      clean(10);

      // three consecutive errors drop lock, clean stream relocks after 10 bits
      bad(2);
      chk("t3_locked_after2", {31'd0, bus.locked}, 32'd1);
      bad(1);
      chk("t3_unlocked", {31'd0, bus.locked}, 32'd0);
      chk("t3_err_count", {24'd0, bus.err_count}, 32'd4);
      clean(9);
      chk("t3_not_relocked_9", {31'd0, bus.locked}, 32'd0);
      clean(1);
      chk("t3_relocked_10", {31'd0, bus.locked}, 32'd1);

      // gaps in din_valid must not disturb the flywheel
      for (int i = 0; i < 40; i++) begin
         clean(1);
         step(1'($urandom_range(0, 1)), 1'b0, 1'b0);
      end
      chk("t5_gaps_err_count", {24'd0, bus.err_count}, 32'd4);

      // 300 isolated errors saturate the counter without losing lock
      for (int i = 0; i < 300; i++) begin
         bad(1);
         clean(1);
      end
      chk("t5_saturated", {24'd0, bus.err_count}, 32'd255);
      chk("t5_sat_locked", {31'd0, bus.locked}, 32'd1);
      step(seq_bits[k % 7], 1'b1, 1'b1);
      k++;
      chk("t5_clr_count", {24'd0, bus.err_count}, 32'd0);
      chk("t5_clr_flag", {31'd0, bus.err_flag}, 32'd0);
      chk("t5_clr_locked", {31'd0, bus.locked}, 32'd1);
      // clear wins over a simultaneous error, pulse still visible
      step(~seq_bits[k % 7], 1'b1, 1'b1);
      k++;
      chk("t5_clr_prio_err", {31'd0, bus.err}, 32'd1);
      chk("t5_clr_prio_count", {24'd0, bus.err_count}, 32'd0);
      chk("t5_clr_prio_flag", {31'd0, bus.err_flag}, 32'd0);

      // asynchronous reset mid-LOCKED
      bad(1);
      #3 reset = 1'b0;
      model_reset();
      #1;
      chk("t6_async_locked", {31'd0, bus.locked}, 32'd0);
      chk("t6_async_count", {24'd0, bus.err_count}, 32'd0);
      chk("t6_async_flag", {31'd0, bus.err_flag}, 32'd0);
      @(posedge clk);
      #1 reset = 1'b1;

      // all-zero stream never locks
      for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'b0);
      chk("t4_zero_locked", {31'd0, bus.locked}, 32'd0);
      chk("t4_zero_count", {24'd0, bus.err_count}, 32'd0);

      // randomised traffic: valid gaps, error bursts, occasional clears
      burst = 0;
      for (int i = 0; i < 3000; i++) begin
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 99) == 0);
         if (burst == 0 && $urandom_range(0, 99) < 3) burst = $urandom_range(1, 4);
         if (v) begin
            d = seq_bits[k % 7] ^ (burst > 0);
            if (burst > 0) burst--;
            k++;
         end else begin
            d = 1'($urandom_range(0, 1));
         end
         step(d, v, c);
      end

      @(negedge clk);
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
